// File: rtl/snake_px_responder.sv
// Avalon-MM pixel-buffer responder: decodes snake-engine pixel writes/reads onto a shared
// single-port frame memory, arbitrating against the VGA scan-out reader.
module snake_px_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0800_0000,
  parameter int unsigned NUM_X        = 320,
  parameter int unsigned NUM_Y        = 240,
  parameter int unsigned MEM_AW       = 17,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       px_address,
  input  logic              px_read,
  input  logic              px_write,
  input  logic [15:0]       px_writedata,
  output logic [15:0]       px_readdata,
  output logic              px_waitrequest,
  input  logic              scan_req,
  input  logic [8:0]        scan_x,
  input  logic [7:0]        scan_y,
  output logic              scan_valid,
  output logic [15:0]       scan_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       wr_count,
  output logic [7:0]        drop_count
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StReadWait, StReadResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [15:0]     wr_q, wr_d;
  logic [7:0]      drop_q, drop_d;
  logic            scan_valid_q;

  logic [8:0]  px_x;
  logic [7:0]  px_y;
  logic [31:0] px_lin, scan_lin;
  logic        hit, req, idle, starve_max;
  logic        av_issue, av_miss, scan_grant;
  logic        wait_c, we_c;

  assign px_x     = px_address[9:1];
  assign px_y     = px_address[17:10];
  assign px_lin   = 32'(px_y) * 32'(NUM_X) + 32'(px_x);
  assign scan_lin = 32'(scan_y) * 32'(NUM_X) + 32'(scan_x);
  assign hit      = (px_address[31:18] == BASE_ADDR[31:18]) &&
                    (32'(px_x) < 32'(NUM_X)) && (32'(px_y) < 32'(NUM_Y));

  assign req        = px_read | px_write;
  assign idle       = (state_q == StIdle);
  assign starve_max = (starve_q == CntW'(STARVE_LIMIT));

  // A decode miss never touches memory, so only in-range requests compete with scan-out.
  assign av_issue   = ~reset & idle & req & hit & (~scan_req | starve_max);
  assign av_miss    = ~reset & idle & req & ~hit;
  assign scan_grant = ~reset & scan_req & ~av_issue;

  always_comb begin
    state_d  = state_q;
    starve_d = '0;
    rdata_d  = rdata_q;
    wait_c   = 1'b1;
    we_c     = 1'b0;
    mem_addr = scan_lin[MEM_AW-1:0];
    unique case (state_q)
      StIdle: begin
        if (!req || av_miss) begin
          wait_c = 1'b0;
        end else if (av_issue) begin
          mem_addr = px_lin[MEM_AW-1:0];
          if (px_write) begin
            we_c   = 1'b1;
            wait_c = 1'b0;
          end else begin
            state_d = StReadWait;
          end
        end else begin
          starve_d = starve_max ? starve_q : starve_q + CntW'(1);
        end
      end
      StReadWait: begin
        rdata_d = mem_rdata;
        state_d = StReadResp;
      end
      StReadResp: begin
        wait_c  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_d   = wr_q;
    drop_d = drop_q;
    if (av_issue && px_write) wr_d = wr_q + 16'd1;
    if (av_miss && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      starve_q     <= '0;
      rdata_q      <= '0;
      wr_q         <= '0;
      drop_q       <= '0;
      scan_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rdata_q      <= rdata_d;
      wr_q         <= wr_d;
      drop_q       <= drop_d;
      scan_valid_q <= scan_grant;
    end
  end

  // Read data is only presented in the completing cycle; misses and idle return zero.
  assign px_readdata    = (state_q == StReadResp) ? rdata_q : 16'h0000;
  assign px_waitrequest = reset | wait_c;
  assign mem_we         = ~reset & we_c;
  assign mem_wdata      = px_writedata;
  assign scan_valid     = scan_valid_q;
  assign scan_rdata     = scan_valid_q ? mem_rdata : 16'h0000;
  assign wr_count       = wr_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_snake_px_responder.sv
// Self-checking bench for snake_px_responder: table-driven single-cycle vectors plus
// directed sequences for reads, starvation, saturation, wrap and mid-read reset.
module tb_snake_px_responder;

  localparam logic [31:0] Base = 32'h0800_0000;

  logic        clk, reset;
  logic [31:0] px_address;
  logic        px_read, px_write;
  logic [15:0] px_writedata, px_readdata;
  logic        px_waitrequest;
  logic        scan_req;
  logic [8:0]  scan_x;
  logic [7:0]  scan_y;
  logic        scan_valid;
  logic [15:0] scan_rdata;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] wr_count;
  logic [7:0]  drop_count;

  logic [15:0] mem [0:(1<<17)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr   = 0;

  snake_px_responder dut (
    .clk            (clk),
    .reset          (reset),
    .px_address     (px_address),
    .px_read        (px_read),
    .px_write       (px_write),
    .px_writedata   (px_writedata),
    .px_readdata    (px_readdata),
    .px_waitrequest (px_waitrequest),
    .scan_req       (scan_req),
    .scan_x         (scan_x),
    .scan_y         (scan_y),
    .scan_valid     (scan_valid),
    .scan_rdata     (scan_rdata),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .wr_count       (wr_count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAM: one port, read-first, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    logic        sreq;
    logic [8:0]  sx;
    logic [7:0]  sy;
    logic        e_wait;
    logic        e_we;
    logic [16:0] e_maddr;
    logic        e_sv;
    logic [15:0] e_wr;
    logic [7:0]  e_drop;
  } vec_t;

  function automatic logic [31:0] pa(input int x, input int y);
    return Base | 32'(y << 10) | 32'(x << 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    px_read  = 1'b0;
    px_write = 1'b0;
    scan_req = 1'b0;
  endtask

  task automatic do_read(input int x, input int y, input logic [15:0] exp);
    px_address = pa(x, y);
    px_read    = 1'b1;
    #1;
    chk("rd_wait1", 32'(px_waitrequest), 32'd1);
    chk("rd_issue_addr", 32'(mem_addr), 32'(y * 320 + x));
    tick();
    chk("rd_wait2", 32'(px_waitrequest), 32'd1);
    tick();
    chk("rd_wait3", 32'(px_waitrequest), 32'd0);
    chk("rd_data", 32'(px_readdata), 32'(exp));
    tick();
    px_read = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{pa(5, 3),     0, 1, 16'hF800, 0, 0, 0, 0, 1, 17'd965,   0, 16'd1, 8'd0};
    vecs[1] = '{pa(319, 239), 0, 1, 16'h001F, 0, 0, 0, 0, 1, 17'd76799, 0, 16'd2, 8'd0};
    vecs[2] = '{pa(320, 0),   0, 1, 16'h1111, 1, 7, 2, 0, 0, 17'd647,   1, 16'd2, 8'd1};
    vecs[3] = '{pa(0, 240),   0, 1, 16'h2222, 0, 0, 0, 0, 0, 17'd0,     0, 16'd2, 8'd2};
    vecs[4] = '{32'h0900_0000 | pa(5, 3), 0, 1, 16'h3333, 0, 0, 0, 0, 0, 17'd0, 0, 16'd2, 8'd3};
    vecs[5] = '{pa(400, 1),   1, 0, 16'h0000, 1, 1, 1, 0, 0, 17'd321,   1, 16'd2, 8'd4};
    vecs[6] = '{32'h0,        0, 0, 16'h0000, 1, 0, 0, 0, 0, 17'd0,     1, 16'd2, 8'd4};
    vecs[7] = '{pa(0, 0),     0, 1, 16'hAAAA, 0, 0, 0, 0, 1, 17'd0,     0, 16'd3, 8'd4};

    reset = 1'b1;
    px_address = '0; px_writedata = '0; scan_x = '0; scan_y = '0;
    idle_inputs();
    tick();
    tick();
    chk("reset_wait", 32'(px_waitrequest), 32'd1);
    chk("reset_we", 32'(mem_we), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_wait", 32'(px_waitrequest), 32'd0);
    chk("post_reset_wr", 32'(wr_count), 32'd0);
    chk("post_reset_drop", 32'(drop_count), 32'd0);
    chk("post_reset_sv", 32'(scan_valid), 32'd0);
    chk("post_reset_rdata", 32'(px_readdata), 32'd0);

    for (int i = 0; i < 8; i++) begin
      px_address   = vecs[i].addr;
      px_read      = vecs[i].rd;
      px_write     = vecs[i].wr;
      px_writedata = vecs[i].wdata;
      scan_req     = vecs[i].sreq;
      scan_x       = vecs[i].sx;
      scan_y       = vecs[i].sy;
      #1;
      chk($sformatf("v%0d_wait", i), 32'(px_waitrequest), 32'(vecs[i].e_wait));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_rdata", i), 32'(px_readdata), 32'd0);
      if (vecs[i].e_we || vecs[i].sreq)
        chk($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
      tick();
      chk($sformatf("v%0d_sv", i), 32'(scan_valid), 32'(vecs[i].e_sv));
      chk($sformatf("v%0d_wrcnt", i), 32'(wr_count), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vecs[i].e_drop));
    end
    idle_inputs();
    exp_wr = 3;

    do_read(5, 3, 16'hF800);
    do_read(319, 239, 16'h001F);

    // Write held off by continuous scan traffic until the starvation limit trips.
    px_address = pa(10, 10); px_writedata = 16'hDEAD; px_write = 1'b1;
    scan_req = 1'b1; scan_x = 9'd5; scan_y = 8'd3;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("starve_c%0d_wait", c), 32'(px_waitrequest), (c < 5) ? 32'd1 : 32'd0);
      chk($sformatf("starve_c%0d_we", c), 32'(mem_we), (c < 5) ? 32'd0 : 32'd1);
      chk($sformatf("starve_c%0d_addr", c), 32'(mem_addr), (c < 5) ? 32'd965 : 32'd3210);
      tick();
      if (c < 5) begin
        chk($sformatf("starve_c%0d_sv", c), 32'(scan_valid), 32'd1);
        chk($sformatf("starve_c%0d_srd", c), 32'(scan_rdata), 32'hF800);
      end
    end
    exp_wr++;
    px_write = 1'b0;
    chk("starve_gap_sv", 32'(scan_valid), 32'd0);
    chk("starve_gap_srd", 32'(scan_rdata), 32'd0);
    tick();
    chk("starve_resume_sv", 32'(scan_valid), 32'd1);
    chk("starve_resume_srd", 32'(scan_rdata), 32'hF800);
    chk("starve_wrcnt", 32'(wr_count), 32'(exp_wr));
    scan_req = 1'b0;
    tick();
    do_read(10, 10, 16'hDEAD);

    // Simultaneous read and write behaves as a plain write.
    px_address = pa(20, 0); px_writedata = 16'h1234; px_write = 1'b1; px_read = 1'b1;
    #1;
    chk("rw_wait", 32'(px_waitrequest), 32'd0);
    chk("rw_we", 32'(mem_we), 32'd1);
    chk("rw_addr", 32'(mem_addr), 32'd20);
    tick();
    exp_wr++;
    idle_inputs();
    #1;
    chk("rw_no_read_wait", 32'(px_waitrequest), 32'd0);
    chk("rw_wrcnt", 32'(wr_count), 32'(exp_wr));
    do_read(20, 0, 16'h1234);

    px_address = pa(320, 0); px_write = 1'b1;
    for (int i = 0; i < 256; i++) tick();
    px_write = 1'b0;
    chk("drop_saturate", 32'(drop_count), 32'd255);

    px_address = pa(1, 1); px_writedata = 16'h5A5A; px_write = 1'b1;
    for (int i = exp_wr; i < 65536; i++) tick();
    px_write = 1'b0;
    chk("wr_wrap", 32'(wr_count), 32'd0);

    // Reset lands while a read is waiting on memory.
    tick();
    px_address = pa(5, 3); px_read = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_wait", 32'(px_waitrequest), 32'd1);
    chk("rst_mid_rdata", 32'(px_readdata), 32'd0);
    chk("rst_mid_drop", 32'(drop_count), 32'd0);
    chk("rst_mid_wr", 32'(wr_count), 32'd0);
    chk("rst_mid_sv", 32'(scan_valid), 32'd0);
    px_read = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_after_wait", 32'(px_waitrequest), 32'd0);
    tick();
    chk("rst_after_wait2", 32'(px_waitrequest), 32'd0);
    chk("rst_after_rdata", 32'(px_readdata), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
